// File: rtl/sid_pkg.sv
// Purpose: shared types and widths for the SID voice mixer.
// Contents: mixer sequencer states, datapath widths, default 6581 DC offset.
package sid_pkg;

  localparam int unsigned SID_VOICE_W = 22;
  localparam int unsigned SID_ACC_W   = 24;
  localparam int unsigned SID_EXT_W   = 16;
  localparam int unsigned SID_VOL_W   = 4;
  // Mix intermediate: d_acc + filt_ret + DC without overflow
  localparam int unsigned SID_MIX_W   = 26;
  // Mix value times an unsigned 4-bit volume
  localparam int unsigned SID_PROD_W  = 31;
  // Fixed-point position of the volume scaling
  localparam int unsigned SID_VOL_SHR = 10;

  localparam logic signed [SID_ACC_W-1:0] DC_6581_DEFAULT = 24'sh03_8000;

  typedef enum logic [2:0] {
    IDLE,
    ACC1,
    ACC2,
    ACC3,
    ACCX,
    MIX,
    SCALE,
    OUT
  } mix_state_e;

endpackage

// File: rtl/sid_sat.sv
// Purpose: combinational signed saturator, IN_W -> OUT_W bits (requires IN_W > OUT_W).
// Ports:
//   i_din     in   IN_W   signed value
//   o_dout_c  out  OUT_W  value clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module sid_sat #(
  parameter int unsigned IN_W  = 21,
  parameter int unsigned OUT_W = 18
) (
  input  logic signed [IN_W-1:0]  i_din,
  output logic signed [OUT_W-1:0] o_dout_c
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  // Clamp instead of wrapping
  always_comb begin
    o_dout_c = OUT_W'(i_din);
    if (i_din > MAX_V) begin
      o_dout_c = OUT_W'(MAX_V);
    end else if (i_din < MIN_V) begin
      o_dout_c = OUT_W'(MIN_V);
    end
  end

endmodule

// File: rtl/sid_voice_mixer.sv
// Purpose: routes three voices and the external input into filter-bound and direct sums,
//   merges the direct sum with the filter return, adds the 6581 DC offset and applies
//   master volume. One sample per ce_1m through a sequencer sharing one adder and one
//   multiplier.
// Ports:
//   clock, reset        clock, asynchronous active-high reset
//   ce_1m               1 MHz sample strobe (one clock wide)
//   mode                0=6581 (DC offset added), 1=8580
//   voice1..voice3      signed 22-bit voice samples
//   ext_in              signed 16-bit external input
//   filt_sel            {ext,v3,v2,v1}, 1 = source goes to the filter
//   voice3_off          mutes voice 3 on the direct path only
//   volume              master volume 0..15
//   filt_ret            signed filter output, used at MIX
//   filt_in/filt_valid  filter-bound sum and its update pulse
//   audio_out/audio_valid  saturated final mix and its update pulse
//   overrun             sticky: strobe arrived while busy
module sid_voice_mixer
  import sid_pkg::*;
#(
  parameter logic signed [SID_ACC_W-1:0] DC_6581   = DC_6581_DEFAULT,
  parameter int unsigned                 EXT_SHIFT = 6,
  parameter int unsigned                 OUT_W     = 18
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ce_1m,
  input  logic                          mode,
  input  logic signed [SID_VOICE_W-1:0] voice1,
  input  logic signed [SID_VOICE_W-1:0] voice2,
  input  logic signed [SID_VOICE_W-1:0] voice3,
  input  logic signed [SID_EXT_W-1:0]   ext_in,
  input  logic [3:0]                    filt_sel,
  input  logic                          voice3_off,
  input  logic [SID_VOL_W-1:0]          volume,
  input  logic signed [SID_ACC_W-1:0]   filt_ret,
  output logic signed [SID_ACC_W-1:0]   filt_in,
  output logic                          filt_valid,
  output logic signed [OUT_W-1:0]       audio_out,
  output logic                          audio_valid,
  output logic                          overrun
);

  localparam int unsigned SID_SHR_W = SID_PROD_W - SID_VOL_SHR;

  mix_state_e r_state;
  mix_state_e w_next;

  logic signed [SID_VOICE_W-1:0] r_v1, r_v2, r_v3;
  logic signed [SID_EXT_W-1:0]   r_ext;
  logic [3:0]                    r_fsel;
  logic                          r_v3off;
  logic [SID_VOL_W-1:0]          r_vol;
  logic                          r_mode;
  logic signed [SID_ACC_W-1:0]   r_f_acc;
  logic signed [SID_ACC_W-1:0]   r_d_acc;
  logic signed [SID_MIX_W-1:0]   r_m;
  logic signed [SID_PROD_W-1:0]  r_p;

  logic signed [SID_MIX_W-1:0]   w_src;
  logic                          w_to_filt;
  logic signed [SID_MIX_W-1:0]   w_add_a, w_add_b, w_add_c, w_sum;
  logic signed [SID_PROD_W-1:0]  w_prod;
  logic signed [SID_SHR_W-1:0]   w_p_shr;
  logic signed [OUT_W-1:0]       w_sat;
  logic                          w_unused_lsb;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus operand selection for the shared adder
  always_comb begin
    w_next    = r_state;
    w_src     = '0;
    w_to_filt = 1'b0;
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_c   = '0;
    unique case (r_state)
      IDLE:  if (ce_1m) w_next = ACC1;
      ACC1: begin
        w_src     = SID_MIX_W'(r_v1);
        w_to_filt = r_fsel[0];
        w_next    = ACC2;
      end
      ACC2: begin
        w_src     = SID_MIX_W'(r_v2);
        w_to_filt = r_fsel[1];
        w_next    = ACC3;
      end
      ACC3: begin
        // voice3_off only silences the direct path
        if (r_fsel[2] || !r_v3off) w_src = SID_MIX_W'(r_v3);
        w_to_filt = r_fsel[2];
        w_next    = ACCX;
      end
      ACCX: begin
        w_src     = SID_MIX_W'(r_ext) <<< EXT_SHIFT;
        w_to_filt = r_fsel[3];
        w_next    = MIX;
      end
      MIX:   w_next = SCALE;
      SCALE: w_next = OUT;
      OUT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase

    if (r_state == MIX) begin
      w_add_a = SID_MIX_W'(r_d_acc);
      w_add_b = SID_MIX_W'(filt_ret);
      if (!r_mode) w_add_c = SID_MIX_W'(DC_6581);
    end else begin
      w_add_a = w_to_filt ? SID_MIX_W'(r_f_acc) : SID_MIX_W'(r_d_acc);
      w_add_b = w_src;
    end
  end

  assign w_sum        = w_add_a + w_add_b + w_add_c;
  assign w_prod       = SID_PROD_W'(r_m) * SID_PROD_W'($signed({1'b0, r_vol}));
  assign w_p_shr      = $signed(r_p[SID_PROD_W-1:SID_VOL_SHR]);
  assign w_unused_lsb = ^r_p[SID_VOL_SHR-1:0];

  sid_sat #(
    .IN_W (SID_SHR_W),
    .OUT_W(OUT_W)
  ) u_sat (
    .i_din   (w_p_shr),
    .o_dout_c(w_sat)
  );

  // Snapshot, accumulation, mix/scale datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v1        <= '0;
      r_v2        <= '0;
      r_v3        <= '0;
      r_ext       <= '0;
      r_fsel      <= '0;
      r_v3off     <= 1'b0;
      r_vol       <= '0;
      r_mode      <= 1'b0;
      r_f_acc     <= '0;
      r_d_acc     <= '0;
      r_m         <= '0;
      r_p         <= '0;
      filt_in     <= '0;
      filt_valid  <= 1'b0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      filt_valid  <= 1'b0;
      audio_valid <= 1'b0;
      if (ce_1m && (r_state != IDLE)) overrun <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (ce_1m) begin
            r_v1    <= voice1;
            r_v2    <= voice2;
            r_v3    <= voice3;
            r_ext   <= ext_in;
            r_fsel  <= filt_sel;
            r_v3off <= voice3_off;
            r_vol   <= volume;
            r_mode  <= mode;
            r_f_acc <= '0;
            r_d_acc <= '0;
          end
        end
        ACC1, ACC2, ACC3: begin
          if (w_to_filt) r_f_acc <= SID_ACC_W'(w_sum);
          else           r_d_acc <= SID_ACC_W'(w_sum);
        end
        ACCX: begin
          if (w_to_filt) begin
            r_f_acc <= SID_ACC_W'(w_sum);
            filt_in <= SID_ACC_W'(w_sum);
          end else begin
            r_d_acc <= SID_ACC_W'(w_sum);
            filt_in <= r_f_acc;
          end
          filt_valid <= 1'b1;
        end
        MIX:   r_m <= w_sum;
        SCALE: r_p <= w_prod;
        OUT: begin
          audio_out   <= w_sat;
          audio_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
